uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Downstream consumer of the IO controller's UART command path (send strobe plus 8-bit out1 byte).
- Buffers bytes in a small synchronous FIFO and serialises them on a single TX pin as 8N1 frames, LSB first, at a fixed baud set by a clock divider.
- Reports FIFO status back to the IO controller so software can poll before issuing UARTSEND.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- send  input  1  one-cycle write strobe from IO controller.
- data  input  8  byte to transmit; sampled when send=1.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- full  output  1  FIFO holds 2**FIFO_AW bytes.
- level  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
- ovf  output  1  one-cycle pulse when send arrives while full; the byte is dropped.

Behaviour:
- Reset (async): tx=1, busy=0, full=0, level=0, ovf=0. FIFO pointers cleared, FSM to IDLE, counters to 0. Reset mid-frame aborts the frame; tx returns high immediately and all queued bytes are discarded.
- Push: on a rising edge with send=1 and full=0, data is written and level increments.
  - send=1 with full=1: no write, ovf=1 for that cycle (registered, so visible the following cycle), level unchanged.
  - Push is judged against the registered full. A pop in the same cycle does not make room for that push.
- Pop: occurs only in IDLE when level!=0. The byte moves to shift register sh, level decrements, and the FSM enters START.
- Simultaneous push and pop (full=0): level unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts 0..CLKS_PER_BIT-1; bit_cnt counts 0..7.
  - IDLE: tx=1. Pop if non-empty, then go to START with baud_cnt=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift right. After bit_cnt=7 completes, go to STOP; otherwise increment bit_cnt.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. Back-to-back frames are allowed: IDLE may pop on its first cycle, so inter-frame gap is 1 clk.
- tx is a registered output (glitch-free).
- Latency: with FSM idle and FIFO empty, send at edge N means the byte is in the FIFO after edge N, popped at edge N+1, and tx falls low after edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT clk from tx fall to the start of the next IDLE cycle.
- busy = (state!=IDLE) | (level!=0), registered.
- Pointer wrap: modulo 2**FIFO_AW. full/empty are derived from level, not from pointer equality.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP} (2-bit).
  - UART_DATA_W=8, UART_STOP_BITS=1.
  - Default baud constant CLKS_115200_50M=434.
- Sub-module sync_fifo (parameters DW, AW), exposing push/pop/din/dout/level/full/empty. Its dout is combinational from the read pointer, so a pop in IDLE captures the byte in the same edge.
- The top level holds the FSM, baud counter, shift register and output registers.

Test Plan:
- Single byte, CLKS_PER_BIT=4: send data=0x55 once. tx falls 2 clk after send, then the line carries 0,1,0,1,0,1,0,1,0,1 with 4 clk per bit. busy drops 1 clk after the stop bit ends; level returns to 0.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles. Decoded frames read 0xA5 then 0x3C, the gap between stop bit and next start bit is 1 clk, and level peaks at 1.
- Full/overflow, FIFO_AW=2: push 6 bytes in consecutive cycles with the line busy.
  - First byte is popped immediately, so 5 are stored: 1 in flight, 4 queued, full=1.
  - 6th send gives ovf=1 for one cycle; that byte never appears on tx.
- Push while full with same-cycle pop: hold full, then assert send on the cycle IDLE pops. The byte is rejected (ovf=1) and level goes 4→3.
- Reset mid-frame: assert rst during DATA bit 3 with 3 bytes queued. tx=1 immediately, level=0, busy=0. After release, no frame is emitted until a new send.
- Wrap-around, FIFO_AW=2: stream 20 bytes 0x00..0x13, pacing send on full=0. Decoded sequence matches exactly with no loss; ovf never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int UART_DATA_W     = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int CLKS_115200_50M = 434;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an occupancy counter; dout shows the head entry
// combinationally so a pop captures it on the same edge.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally; full/empty come from the counter, not pointer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign level = level_q;
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB
// first on tx, with all line-facing outputs registered.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_50M,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic [7:0]       data,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic [FIFO_AW:0] level,
    output logic             ovf,
    output state_e           state_dbg
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_W - 1);

    state_e                 state_q;
    logic [15:0]            baud_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [UART_DATA_W-1:0] sh_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   ovf_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [7:0]             fifo_dout;
    logic                   fifo_empty;
    logic                   baud_last;

    // Handshake: send is a one-cycle strobe accepted only when the registered
    // full is low; a same-cycle pop never frees room for it, and a refused
    // byte is dropped with a one-cycle ovf pulse on the next cycle.
    assign fifo_push = send & ~full;
    assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
    assign baud_last = (baud_cnt_q == BAUD_LAST);

    sync_fifo #(
        .DW (UART_DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q  <= send & full;
            busy_q <= (state_q != IDLE) | (level != '0);
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_pop) begin
                        sh_q       <= fifo_dout;
                        baud_cnt_q <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= sh_q[0];
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        sh_q       <= sh_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table-driven single-frame vectors plus
// hand-written multi-cycle sequences, with a line decoder feeding got_q.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int AW  = 2;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bit k in frame[k]: start, d0..d7, stop
    } vec_t;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             send = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             tx;
    logic             busy;
    logic             full;
    logic [AW:0]      level;
    logic             ovf;
    uart_pkg::state_e state_dbg;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [7:0] got_q[$];
    int         fall_q[$];
    vec_t       vecs[6];
    logic [7:0] fb[6];
    int         exp_lvl[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .data      (data),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .level     (level),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("frame_wait_in_budget", 32'(got_q.size() >= n), 1);
    endtask

    task automatic chk_got(input int i, input logic [7:0] exp);
        logic [7:0] g;
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        chk($sformatf("got_byte%0d", i), 32'(g), 32'(exp));
    endtask

    // Line decoder: first low sample is index 0, bits sampled mid-period.
    initial begin : mon
        logic [7:0] b;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                fall_q.push_back(cyc);
                aborted = 1'b0;
                b = 8'h00;
                for (int idx = 1; idx <= 38; idx++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    if (!aborted) begin
                        if (idx == 2) chk("start_bit_mid", 32'(tx), 0);
                        if (idx >= 6 && idx <= 34 && ((idx - 6) % 4) == 0) b[(idx - 6) / 4] = tx;
                        if (idx == 38) chk("stop_bit_mid", 32'(tx), 1);
                    end
                end
                if (!aborted) got_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       ovf_seen;
        int         lows;
        int         t;
        int         max_lvl;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'hA5, frame: 10'h34A};
        vecs[2] = '{data: 8'h00, frame: 10'h200};
        vecs[3] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[4] = '{data: 8'h01, frame: 10'h202};
        vecs[5] = '{data: 8'h80, frame: 10'h300};
        fb      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_lvl = '{1, 1, 2, 3, 4, 4};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // Single-frame vectors: exact cycle-by-cycle line check.
        for (int v = 0; v < 6; v++) begin
            send = 1'b1;
            data = vecs[v].data;
            tick();
            send = 1'b0;
            chk($sformatf("v%0d_level_push", v), 32'(level), 1);
            chk($sformatf("v%0d_busy_push", v), 32'(busy), 0);
            chk($sformatf("v%0d_tx_push", v), 32'(tx), 1);
            tick();
            chk($sformatf("v%0d_level_pop", v), 32'(level), 0);
            chk($sformatf("v%0d_busy_pop", v), 32'(busy), 1);
            chk($sformatf("v%0d_tx_pop", v), 32'(tx), 1);
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    tick();
                    chk($sformatf("v%0d_bit%0d_c%0d", v, k, c), 32'(tx), 32'(vecs[v].frame[k]));
                end
            end
            chk($sformatf("v%0d_busy_last_stop", v), 32'(busy), 1);
            tick();
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 0);
            chk($sformatf("v%0d_tx_end", v), 32'(tx), 1);
            chk($sformatf("v%0d_level_end", v), 32'(level), 0);
        end

        // Back-to-back frames.
        got_q.delete();
        fall_q.delete();
        send = 1'b1;
        data = 8'hA5;
        tick();
        chk("b2b_level_e1", 32'(level), 1);
        data = 8'h3C;
        tick();
        send = 1'b0;
        chk("b2b_level_push_pop", 32'(level), 1);
        max_lvl = 1;
        t = 0;
        while (got_q.size() < 2 && t < 200) begin
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            t++;
        end
        chk("b2b_in_budget", 32'(got_q.size() >= 2), 1);
        chk("b2b_level_peak", 32'(max_lvl), 1);
        chk_got(0, 8'hA5);
        chk_got(1, 8'h3C);
        chk("b2b_fall_spacing", 32'((fall_q.size() >= 2) ? (fall_q[1] - fall_q[0]) : 0), 10 * CPB + 1);
        repeat (10) tick();

        // Fill, overflow, then a push on the same cycle IDLE pops.
        got_q.delete();
        fall_q.delete();
        for (int i = 0; i < 6; i++) begin
            send = 1'b1;
            data = fb[i];
            tick();
            chk($sformatf("full_level_e%0d", i + 1), 32'(level), 32'(exp_lvl[i]));
            chk($sformatf("full_ovf_e%0d", i + 1), 32'(ovf), 32'(i == 5));
            chk($sformatf("full_flag_e%0d", i + 1), 32'(full), 32'(i >= 4));
        end
        send = 1'b0;
        tick();
        chk("ovf_one_cycle", 32'(ovf), 0);
        chk("full_level_e7", 32'(level), 4);
        repeat (35) tick();
        chk("full_level_e42", 32'(level), 4);
        chk("full_flag_e42", 32'(full), 1);
        send = 1'b1;
        data = 8'h77;
        tick();
        send = 1'b0;
        chk("popfull_ovf", 32'(ovf), 1);
        chk("popfull_level", 32'(level), 3);
        chk("popfull_full", 32'(full), 0);
        tick();
        chk("popfull_ovf_clear", 32'(ovf), 0);
        chk("popfull_level_hold", 32'(level), 3);
        wait_frames(5, 400);
        repeat (60) tick();
        chk("full_frame_count", 32'(got_q.size()), 5);
        for (int i = 0; i < 5; i++) chk_got(i, fb[i]);

        // Reset in the middle of DATA bit 3 with three bytes queued.
        got_q.delete();
        fall_q.delete();
        send = 1'b1;
        data = 8'h00; tick();
        data = 8'h81; tick();
        data = 8'h42; tick();
        data = 8'h24; tick();
        send = 1'b0;
        repeat (15) tick();
        chk("midrst_tx_before", 32'(tx), 0);
        chk("midrst_level_before", 32'(level), 3);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_full", 32'(full), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        lows = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("postrst_line_idle", 32'(lows), 0);
        chk("postrst_no_frames", 32'(got_q.size()), 0);
        chk("postrst_level", 32'(level), 0);
        chk("postrst_busy", 32'(busy), 0);
        send = 1'b1;
        data = 8'h5A;
        tick();
        send = 1'b0;
        wait_frames(1, 100);
        chk_got(0, 8'h5A);
        repeat (10) tick();

        // Stream 20 bytes paced on full; pointers wrap several times.
        got_q.delete();
        fall_q.delete();
        ovf_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t = 0;
            while (full === 1'b1 && t < 200) begin
                tick();
                if (ovf !== 1'b0) ovf_seen = 1'b1;
                t++;
            end
            send = 1'b1;
            data = 8'(i);
            tick();
            send = 1'b0;
            if (ovf !== 1'b0) ovf_seen = 1'b1;
        end
        tick();
        if (ovf !== 1'b0) ovf_seen = 1'b1;
        wait_frames(20, 1500);
        chk("wrap_frame_count", 32'(got_q.size()), 20);
        for (int i = 0; i < 20; i++) chk_got(i, 8'(i));
        chk("wrap_no_ovf", 32'(ovf_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
